// File: rtl/vic_irq_scheduler.sv
// vic_irq_scheduler: latches request edges and picks the highest-priority enabled source.
// It presents that source to the CPU and then sequences claim, service and end-of-interrupt.
module vic_irq_scheduler #(
    parameter int NUM_SRC   = 32,
    parameter int CFG_WIDTH = 4,
    parameter int VEC_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC*CFG_WIDTH-1:0] i_cfg_buffer,
    input  logic [NUM_SRC-1:0]           i_irq_src,
    input  logic                         i_ack,
    input  logic                         i_eoi,
    output logic                         o_irq,
    output logic [VEC_WIDTH-1:0]         o_vector,
    output logic [2:0]                   o_prio,
    output logic                         o_busy,
    output logic [NUM_SRC-1:0]           o_pending
);
    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
    state_t                 state_q, state_d;
    logic [NUM_SRC-1:0]     pending_q, pending_d, prev_q, en, elig, clr;
    logic [2:0]             prio [NUM_SRC];
    logic [VEC_WIDTH-1:0]   vector_q, vector_d, win_idx;
    logic [2:0]             prio_q, prio_d, win_prio;
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            en[i]   = i_cfg_buffer[CFG_WIDTH*i+CFG_WIDTH-1];
            prio[i] = i_cfg_buffer[CFG_WIDTH*i +: 3];
        end
        elig = pending_q & en;
    end
    // Scanning downward with >= leaves the lowest index among equal top priorities.
    always_comb begin
        win_idx  = '0;
        win_prio = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i] && prio[i] >= win_prio) begin
                win_idx  = VEC_WIDTH'(i);
                win_prio = prio[i];
            end
        end
    end
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        prio_d   = prio_q;
        clr      = '0;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d  = ASSERT;
                    vector_d = win_idx;
                    prio_d   = win_prio;
                end
            end
            ASSERT: begin
                if (i_ack) begin
                    state_d       = SERVICE;
                    clr[vector_q] = 1'b1;
                end else if (!en[vector_q]) begin
                    state_d  = IDLE;
                    vector_d = '0;
                    prio_d   = '0;
                end else if (win_prio > prio_q) begin
                    vector_d = win_idx;
                    prio_d   = win_prio;
                end
            end
            SERVICE: begin
                if (i_eoi) begin
                    state_d  = IDLE;
                    vector_d = '0;
                    prio_d   = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                vector_d = '0;
                prio_d   = '0;
            end
        endcase
        // A new edge wins over the claim clear on the same source.
        pending_d = (pending_q & ~clr) | (i_irq_src & ~prev_q);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            prev_q    <= '0;
            vector_q  <= '0;
            prio_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            prev_q    <= i_irq_src;
            vector_q  <= vector_d;
            prio_q    <= prio_d;
        end
    end
    assign o_irq     = state_q == ASSERT;
    assign o_busy    = state_q == SERVICE;
    assign o_vector  = vector_q;
    assign o_prio    = prio_q;
    assign o_pending = pending_q;
endmodule

// File: tb/tb_vic_irq_scheduler.sv
// tb_vic_irq_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_vic_irq_scheduler;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] cfg;
    logic [31:0]  src;
    logic         ack, eoi;
    logic         o_irq, o_busy;
    logic [4:0]   o_vector;
    logic [2:0]   o_prio;
    logic [31:0]  o_pending;

    vic_irq_scheduler dut (
        .clk(clk), .rst(rst), .i_cfg_buffer(cfg), .i_irq_src(src),
        .i_ack(ack), .i_eoi(eoi), .o_irq(o_irq), .o_vector(o_vector),
        .o_prio(o_prio), .o_busy(o_busy), .o_pending(o_pending)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int          m_state;
    logic [31:0] m_pend, m_prev;
    logic [4:0]  m_vec;
    logic [2:0]  m_prio;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit en_of(input int i);
        return cfg[4*i+3];
    endfunction

    function automatic int prio_of(input int i);
        logic [3:0] c;
        c = cfg[4*i +: 4];
        return int'(c[2:0]);
    endfunction

    function automatic int pick();
        for (int p = 7; p >= 0; p--)
            for (int i = 0; i < 32; i++)
                if (m_pend[i] && en_of(i) && prio_of(i) == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pend = '0; m_prev = '0; m_vec = '0; m_prio = '0;
    endtask

    task automatic model_edge();
        int w;
        logic [31:0] rise, clr;
        rise = src & ~m_prev;
        m_prev = src;
        clr = '0;
        w = pick();
        if (m_state == 0) begin
            if (w >= 0) begin m_state = 1; m_vec = 5'(w); m_prio = 3'(prio_of(w)); end
        end else if (m_state == 1) begin
            if (ack) begin clr[m_vec] = 1'b1; m_state = 2; end
            else if (!en_of(int'(m_vec))) begin m_state = 0; m_vec = '0; m_prio = '0; end
            else if (w >= 0 && prio_of(w) > int'(m_prio)) begin m_vec = 5'(w); m_prio = 3'(prio_of(w)); end
        end else if (eoi) begin
            m_state = 0; m_vec = '0; m_prio = '0;
        end
        m_pend = (m_pend & ~clr) | rise;
    endtask

    task automatic check_all();
        chk("irq",     32'(o_irq),    32'(m_state == 1));
        chk("busy",    32'(o_busy),   32'(m_state == 2));
        chk("vector",  32'(o_vector), 32'(m_vec));
        chk("prio",    32'(o_prio),   32'(m_prio));
        chk("pending", o_pending,     m_pend);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_cfg(input int i, input logic [3:0] v);
        cfg[4*i +: 4] = v;
    endtask

    task automatic serve();
        ack = 1'b1; step(); ack = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0; cfg = '0; src = '0; ack = 1'b0; eoi = 1'b0;
        model_reset();
        #12;
        chk("rst_irq", 32'(o_irq), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_vec", 32'(o_vector), 32'd0);
        chk("rst_pend", o_pending, 32'd0);
        rst = 1'b1;

        // single source
        set_cfg(5, 4'b1011);
        src[5] = 1'b1; step(); src[5] = 1'b0;
        chk("s1_pend", 32'(o_pending[5]), 32'd1);
        chk("s1_noirq", 32'(o_irq), 32'd0);
        step();
        chk("s1_irq", 32'(o_irq), 32'd1);
        chk("s1_vec", 32'(o_vector), 32'd5);
        chk("s1_prio", 32'(o_prio), 32'd3);
        ack = 1'b1; step(); ack = 1'b0;
        chk("s1_busy", 32'(o_busy), 32'd1);
        chk("s1_clr", 32'(o_pending[5]), 32'd0);
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        chk("s1_idle", 32'(o_irq), 32'd0);

        // priority and tie-break
        set_cfg(3, 4'b1010); set_cfg(9, 4'b1110); set_cfg(20, 4'b1110);
        src[3] = 1'b1; src[9] = 1'b1; src[20] = 1'b1; step(); src = '0;
        step();
        chk("tie_first", 32'(o_vector), 32'd9);
        serve();
        chk("tie_second", 32'(o_vector), 32'd20);
        serve();
        chk("tie_third", 32'(o_vector), 32'd3);
        chk("tie_third_prio", 32'(o_prio), 32'd2);
        serve();

        // disabled source
        set_cfg(7, 4'b0100);
        src[7] = 1'b1; step(); src[7] = 1'b0;
        step();
        chk("dis_pend", 32'(o_pending[7]), 32'd1);
        chk("dis_noirq", 32'(o_irq), 32'd0);
        set_cfg(7, 4'b1100);
        step();
        chk("dis_en_irq", 32'(o_irq), 32'd1);
        chk("dis_en_vec", 32'(o_vector), 32'd7);
        serve();
        chk("dis_after", 32'(o_irq), 32'd0);

        // preemption and withdrawal
        set_cfg(4, 4'b1001); set_cfg(12, 4'b1101);
        src[4] = 1'b1; step(); src[4] = 1'b0;
        step();
        chk("pre_vec4", 32'(o_vector), 32'd4);
        src[12] = 1'b1; step(); src[12] = 1'b0;
        chk("pre_hold", 32'(o_vector), 32'd4);
        step();
        chk("pre_irq", 32'(o_irq), 32'd1);
        chk("pre_vec12", 32'(o_vector), 32'd12);
        chk("pre_prio", 32'(o_prio), 32'd5);
        set_cfg(12, 4'b0101);
        step();
        chk("wd_irq", 32'(o_irq), 32'd0);
        step();
        chk("wd_back", 32'(o_vector), 32'd4);
        serve();

        // ack colliding with a new rise of the claimed source
        set_cfg(12, 4'b1101);
        step();
        chk("col_vec", 32'(o_vector), 32'd12);
        ack = 1'b1; src[12] = 1'b1; step(); ack = 1'b0; src[12] = 1'b0;
        chk("col_pend", 32'(o_pending[12]), 32'd1);
        ack = 1'b1; step(); ack = 1'b0;
        chk("stray_ack", 32'(o_busy), 32'd1);
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        chk("col_again", 32'(o_vector), 32'd12);
        serve();
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("stray_eoi", 32'(o_irq | o_busy), 32'd0);

        // asynchronous reset in SERVICE
        src[9] = 1'b1; step(); src[9] = 1'b0;
        step();
        ack = 1'b1; step(); ack = 1'b0;
        chk("ar_busy", 32'(o_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("ar_busy0", 32'(o_busy), 32'd0);
        chk("ar_irq0", 32'(o_irq), 32'd0);
        chk("ar_vec0", 32'(o_vector), 32'd0);
        chk("ar_prio0", 32'(o_prio), 32'd0);
        chk("ar_pend0", o_pending, 32'd0);
        rst = 1'b1;

        // randomized traffic, priorities fixed, enables toggling
        for (int i = 0; i < 32; i++) set_cfg(i, 4'($urandom));
        for (int c = 0; c < 600; c++) begin
            src = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 4) == 0) cfg[4*$urandom_range(0, 31) + 3] = 1'($urandom);
            ack = $urandom_range(0, 2) == 0;
            eoi = $urandom_range(0, 3) == 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
